// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial, LSB-first computation of (a - b) mod 2^WIDTH.
// One result bit is produced per clock through a single borrow flop. Operands
// are taken on a start/ready handshake and results are held until the next
// operation completes.
module serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // Handshake: an operation is accepted on a rising edge where start=1 and
    // ready=1 (ready is a pure decode of IDLE). a/b are sampled only on that
    // edge; start while busy is dropped, not queued. done is a one-cycle pulse
    // marking diff/borrow/zero as freshly updated; they then hold until the
    // next done.
    logic [1:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sd;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             x;
    logic             y;
    logic             d;
    logic             br_next;
    logic [WIDTH-1:0] sd_next;
    logic             last_bit;
    logic             accept;

    // Full-subtractor bit op on the current LSBs and the borrow flop.
    always_comb begin
        x        = sa[0];
        y        = sb[0];
        d        = x ^ y ^ br;
        br_next  = (~x & y) | (~(x ^ y) & br);
        sd_next  = {d, sd[WIDTH-1:1]};
        last_bit = (cnt == CW'(WIDTH - 1));
        accept   = (state == IDLE) && start;
    end

    // Status flags decode registered state only; no path from start.
    always_comb begin
        ready = (state == IDLE);
        busy  = (state == SHIFT) || (state == DONE);
    end

    // Control FSM: IDLE -> SHIFT for WIDTH cycles -> DONE for one cycle -> IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state <= SHIFT;
                SHIFT:   if (last_bit) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Serial datapath: load operands on accept, then shift one bit per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa  <= '0;
            sb  <= '0;
            sd  <= '0;
            br  <= 1'b0;
            cnt <= '0;
        end else if (accept) begin
            sa  <= a;
            sb  <= b;
            br  <= 1'b0;
            cnt <= '0;
        end else if (state == SHIFT) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            sd  <= sd_next;
            br  <= br_next;
            cnt <= cnt + CW'(1);
        end
    end

    // Result registers: updated only on the final shift, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff   <= '0;
            borrow <= 1'b0;
            zero   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if ((state == SHIFT) && last_bit) begin
                diff   <= sd_next;
                borrow <= br_next;
                zero   <= (sd_next == '0);
                done   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor at WIDTH=8: directed cases, back-to-back start,
// async reset mid-operation and randomized operands, all checked against a
// plain-arithmetic reference of a - b.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             zero;

    int n_checks;
    int n_pass;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .zero   (zero)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: {borrow, diff} of unsigned a - b via wider arithmetic.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH:0] r;
        r = {1'b0, x} - {1'b0, y};
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        #2;
        n_checks++;
        if ({ready, busy, done, diff, borrow, zero} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0})
            $display("FAIL reset_asserted: got r=%b bz=%b d=%b diff=%h br=%b z=%b want r=1 bz=0 d=0 diff=00 br=0 z=0",
                     ready, busy, done, diff, borrow, zero);
        else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({ready, busy, done, diff, borrow, zero} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0})
            $display("FAIL reset_released: got r=%b bz=%b d=%b diff=%h br=%b z=%b want r=1 bz=0 d=0 diff=00 br=0 z=0",
                     ready, busy, done, diff, borrow, zero);
        else n_pass++;
    endtask

    // One full operation with timing, hold and result checks.
    task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input string tag);
        logic [WIDTH:0]   exp;
        logic [WIDTH-1:0] held;
        logic             held_br;
        logic             held_z;
        int               waited;
        exp     = model(ta, tb);
        held    = diff;
        held_br = borrow;
        held_z  = zero;
        a = ta;
        b = tb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waited = 0;
        while (!done && waited < 40) begin
            n_checks++;
            if ({busy, ready} !== 2'b10)
                $display("FAIL %s busy_phase: cycle %0d got busy=%b ready=%b want busy=1 ready=0", tag, waited, busy, ready);
            else n_pass++;
            n_checks++;
            if ({diff, borrow, zero} !== {held, held_br, held_z})
                $display("FAIL %s results_held: cycle %0d got diff=%h br=%b z=%b want diff=%h br=%b z=%b",
                         tag, waited, diff, borrow, zero, held, held_br, held_z);
            else n_pass++;
            // Operand churn and stray starts while busy must have no effect.
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            start = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            waited++;
        end
        n_checks++;
        if (waited !== WIDTH)
            $display("FAIL %s done_latency: got %0d cycles before done want %0d", tag, waited, WIDTH);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b1)
            $display("FAIL %s busy_in_done: got %b want 1", tag, busy);
        else n_pass++;
        n_checks++;
        if (diff !== exp[WIDTH-1:0])
            $display("FAIL %s diff: got %h want %h", tag, diff, exp[WIDTH-1:0]);
        else n_pass++;
        n_checks++;
        if (borrow !== exp[WIDTH])
            $display("FAIL %s borrow: got %b want %b", tag, borrow, exp[WIDTH]);
        else n_pass++;
        n_checks++;
        if (zero !== (exp[WIDTH-1:0] == '0))
            $display("FAIL %s zero: got %b want %b", tag, zero, (exp[WIDTH-1:0] == '0));
        else n_pass++;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_checks++;
        if ({done, ready, busy} !== 3'b010)
            $display("FAIL %s after_done: got done=%b ready=%b busy=%b want done=0 ready=1 busy=0", tag, done, ready, busy);
        else n_pass++;
        n_checks++;
        if (diff !== exp[WIDTH-1:0])
            $display("FAIL %s diff_hold_idle: got %h want %h", tag, diff, exp[WIDTH-1:0]);
        else n_pass++;
    endtask

    task automatic test_directed();
        do_op(8'h35, 8'h12, "basic_35_12");
        do_op(8'h12, 8'h35, "neg_12_35");
        do_op(8'h00, 8'h01, "wrap_00_01");
        do_op(8'hA5, 8'hA5, "zero_a5_a5");
        do_op(8'hFF, 8'h00, "max_ff_00");
    endtask

    task automatic test_persist();
        do_op(8'h35, 8'h12, "persist_first");
        do_op(8'h01, 8'h02, "persist_second");
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] acc_a;
        logic [WIDTH-1:0] acc_b;
        logic [WIDTH:0]   exp;
        int               waited;
        acc_a = '0;
        acc_b = '0;
        a = 8'h80;
        b = 8'h01;
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int s = 0; s <= WIDTH + 1; s++) begin
            n_checks++;
            if ({ready, busy, done} !== {(s == WIDTH + 1), (s != WIDTH + 1), (s == WIDTH)})
                $display("FAIL b2b_flags: after edge E%0d got r=%b bz=%b d=%b want r=%b bz=%b d=%b",
                         s, ready, busy, done, (s == WIDTH + 1), (s != WIDTH + 1), (s == WIDTH));
            else n_pass++;
            if (s == WIDTH) begin
                n_checks++;
                if (diff !== 8'h7F)
                    $display("FAIL b2b_first_diff: got %h want 7f", diff);
                else n_pass++;
            end
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            acc_a = a;
            acc_b = b;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1)
            $display("FAIL b2b_second_accept: got busy=%b want 1", busy);
        else n_pass++;
        exp = model(acc_a, acc_b);
        waited = 0;
        while (!done && waited < 40) begin
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            @(posedge clk);
            #1;
            waited++;
        end
        n_checks++;
        if (waited !== WIDTH)
            $display("FAIL b2b_second_latency: got %0d want %0d", waited, WIDTH);
        else n_pass++;
        n_checks++;
        if ({borrow, diff} !== exp)
            $display("FAIL b2b_second_result: got br=%b diff=%h want br=%b diff=%h", borrow, diff, exp[WIDTH], exp[WIDTH-1:0]);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_op();
        int saw_done;
        a = 8'h77;
        b = 8'h33;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ready, busy, done, diff, borrow, zero} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0})
            $display("FAIL midop_reset: got r=%b bz=%b d=%b diff=%h br=%b z=%b want r=1 bz=0 d=0 diff=00 br=0 z=0",
                     ready, busy, done, diff, borrow, zero);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        saw_done = 0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) saw_done++;
        end
        n_checks++;
        if (saw_done !== 0)
            $display("FAIL midop_no_done: got %0d busy/done cycles after reset want 0", saw_done);
        else n_pass++;
        do_op(8'h10, 8'h01, "after_reset_10_01");
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            do_op(WIDTH'($urandom), WIDTH'($urandom), "random");
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_directed();
        test_persist();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
